// File: rtl/dsp_cfg_pkg.sv
// Shared configuration definitions for the DSP slice input register stage.
// Holds the register-depth encodings, the serial chain length and the
// layout of the A/B configuration chain.
package dsp_cfg_pkg;

    // Length of the A/B input stage configuration chain.
    localparam int unsigned AB_CFG_BITS = 10;

    // Register-depth encodings for AREG/BREG. The fourth code is an alias of
    // depth two so that every 2-bit value has a defined meaning.
    typedef enum logic [1:0] {
        RegDepth0      = 2'd0,
        RegDepth1      = 2'd1,
        RegDepth2      = 2'd2,
        RegDepth2Alias = 2'd3
    } reg_depth_e;

    // Chain layout, LSB first. configuration_input enters at a_input and
    // configuration_output is taken from is_rstinmode_inverted.
    typedef struct packed {
        logic       is_rstinmode_inverted;  // bit 9
        logic       is_rstb_inverted;       // bit 8
        logic       is_rsta_inverted;       // bit 7
        logic       inmodereg;              // bit 6
        logic [1:0] breg;                   // bits 5:4
        logic [1:0] areg;                   // bits 3:2
        logic       b_input;                // bit 1
        logic       a_input;                // bit 0
    } ab_cfg_t;

    // True when the depth code selects the two-register path (2 or its alias).
    function automatic logic depth_uses_stage1(input logic [1:0] depth);
        return (depth == RegDepth2) || (depth == RegDepth2Alias);
    endfunction

    // True when the depth code bypasses both registers.
    function automatic logic depth_is_comb(input logic [1:0] depth);
        return depth == RegDepth0;
    endfunction

endpackage

// File: rtl/operand_pipe.sv
// Two-register operand pipeline with programmable depth (0, 1 or 2).
// Provides the stage-1 and stage-2 taps used for the pre-adder operand
// select and the cascade output.
module operand_pipe
    import dsp_cfg_pkg::*;
#(
    parameter int unsigned WIDTH = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       depth,
    input  logic             ce1,
    input  logic             ce2,
    input  logic             sync_rst,
    output logic [WIDTH-1:0] stage1_path,
    output logic [WIDTH-1:0] stage2_path
);

    logic [WIDTH-1:0] reg1_q, reg1_d;
    logic [WIDTH-1:0] reg2_q, reg2_d;
    logic             two_deep;
    logic             comb_only;

    assign two_deep  = depth_uses_stage1(depth);
    assign comb_only = depth_is_comb(depth);

    // Next-state for both registers: sync reset beats the clock enable.
    always_comb begin
        reg1_d = reg1_q;
        reg2_d = reg2_q;
        if (sync_rst) begin
            reg1_d = '0;
            reg2_d = '0;
        end else begin
            if (ce1) begin
                reg1_d = din;
            end
            if (ce2) begin
                // In single-register mode the second register samples the input directly.
                reg2_d = two_deep ? reg1_q : din;
            end
        end
    end

    // Pipeline state, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg1_q <= '0;
            reg2_q <= '0;
        end else begin
            reg1_q <= reg1_d;
            reg2_q <= reg2_d;
        end
    end

    // Depth taps: stage 2 feeds the cascade, stage 1 is one register earlier.
    always_comb begin
        stage2_path = comb_only ? din : reg2_q;
        stage1_path = two_deep ? reg1_q : stage2_path;
    end

endmodule

// File: rtl/ab_input_register_block.sv
// A/B operand input register stage of the DSP slice. Selects direct or
// cascade operands, runs the A and B pipelines and the INMODE register, and
// holds its static configuration in a serial shift chain.
module ab_input_register_block
    import dsp_cfg_pkg::*;
#(
    parameter bit input_freezed = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] A,
    input  logic [29:0] ACIN,
    input  logic [17:0] B,
    input  logic [17:0] BCIN,
    input  logic        CEA1,
    input  logic        CEA2,
    input  logic        CEB1,
    input  logic        CEB2,
    input  logic        RSTA,
    input  logic        RSTB,
    input  logic [4:0]  INMODE,
    input  logic        CEINMODE,
    input  logic        RSTINMODE,
    output logic [26:0] A2A1,
    output logic [17:0] B2B1,
    output logic [29:0] ACOUT,
    output logic [17:0] BCOUT,
    output logic [4:0]  INMODE_OUT,
    input  logic        configuration_input,
    input  logic        configuration_enable,
    output logic        configuration_output
);

    // Configuration chain
    ab_cfg_t cfg_q, cfg_d;

    // Shift one bit per clock while enabled; otherwise hold.
    always_comb begin
        cfg_d = cfg_q;
        if (configuration_enable) begin
            cfg_d = ab_cfg_t'({cfg_q[AB_CFG_BITS-2:0], configuration_input});
        end
    end

    // Configuration storage, cleared by rst_n so a partial shift restarts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= '0;
        end else begin
            cfg_q <= cfg_d;
        end
    end

    assign configuration_output = cfg_q.is_rstinmode_inverted;

    // Effective configuration
    logic [1:0] areg_eff;
    logic [1:0] breg_eff;
    logic       inmodereg_eff;

    // Freezing forces the fully registered paths regardless of the chain.
    always_comb begin
        if (input_freezed) begin
            areg_eff      = RegDepth2;
            breg_eff      = RegDepth2;
            inmodereg_eff = 1'b1;
        end else begin
            areg_eff      = cfg_q.areg;
            breg_eff      = cfg_q.breg;
            inmodereg_eff = cfg_q.inmodereg;
        end
    end

    // Input select and reset polarity
    logic [29:0] a_sel;
    logic [17:0] b_sel;
    logic        rsta_x;
    logic        rstb_x;
    logic        rstinmode_x;

    // Operand source and effective synchronous resets.
    always_comb begin
        a_sel       = cfg_q.a_input ? ACIN : A;
        b_sel       = cfg_q.b_input ? BCIN : B;
        rsta_x      = RSTA ^ cfg_q.is_rsta_inverted;
        rstb_x      = RSTB ^ cfg_q.is_rstb_inverted;
        rstinmode_x = RSTINMODE ^ cfg_q.is_rstinmode_inverted;
    end

    // Operand pipelines
    logic [29:0] a1_path;
    logic [29:0] a2_path;
    logic [17:0] b1_path;
    logic [17:0] b2_path;

    operand_pipe #(
        .WIDTH (30)
    ) u_a_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (a_sel),
        .depth       (areg_eff),
        .ce1         (CEA1),
        .ce2         (CEA2),
        .sync_rst    (rsta_x),
        .stage1_path (a1_path),
        .stage2_path (a2_path)
    );

    operand_pipe #(
        .WIDTH (18)
    ) u_b_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (b_sel),
        .depth       (breg_eff),
        .ce1         (CEB1),
        .ce2         (CEB2),
        .sync_rst    (rstb_x),
        .stage1_path (b1_path),
        .stage2_path (b2_path)
    );

    // INMODE register
    logic [4:0] inmode_q, inmode_d;

    // INMODE next state: sync reset beats the clock enable.
    always_comb begin
        inmode_d = inmode_q;
        if (rstinmode_x) begin
            inmode_d = '0;
        end else if (CEINMODE) begin
            inmode_d = INMODE;
        end
    end

    // INMODE storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inmode_q <= '0;
        end else begin
            inmode_q <= inmode_d;
        end
    end

    // Outputs
    // Operand selection towards the pre-adder and the cascade outputs.
    always_comb begin
        INMODE_OUT = inmodereg_eff ? inmode_q : INMODE;
        A2A1       = INMODE_OUT[0] ? a1_path[26:0] : a2_path[26:0];
        B2B1       = INMODE_OUT[4] ? b1_path : b2_path;
        ACOUT      = a2_path;
        BCOUT      = b2_path;
    end

    // The top three stage-1 A bits never reach the pre-adder.
    logic unused_a1_msbs;
    assign unused_a1_msbs = ^a1_path[29:27];

endmodule

// File: tb/tb_ab_input_register_block.sv
// Directed self-checking bench for ab_input_register_block.
module tb_ab_input_register_block;

    logic        clk;
    logic        rst_n;
    logic [29:0] A;
    logic [29:0] ACIN;
    logic [17:0] B;
    logic [17:0] BCIN;
    logic        CEA1, CEA2, CEB1, CEB2;
    logic        RSTA, RSTB;
    logic [4:0]  INMODE;
    logic        CEINMODE;
    logic        RSTINMODE;
    logic [26:0] A2A1;
    logic [17:0] B2B1;
    logic [29:0] ACOUT;
    logic [17:0] BCOUT;
    logic [4:0]  INMODE_OUT;
    logic        configuration_input;
    logic        configuration_enable;
    logic        configuration_output;

    int n_checks = 0;
    int n_fail   = 0;

    ab_input_register_block dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .A                    (A),
        .ACIN                 (ACIN),
        .B                    (B),
        .BCIN                 (BCIN),
        .CEA1                 (CEA1),
        .CEA2                 (CEA2),
        .CEB1                 (CEB1),
        .CEB2                 (CEB2),
        .RSTA                 (RSTA),
        .RSTB                 (RSTB),
        .INMODE               (INMODE),
        .CEINMODE             (CEINMODE),
        .RSTINMODE            (RSTINMODE),
        .A2A1                 (A2A1),
        .B2B1                 (B2B1),
        .ACOUT                (ACOUT),
        .BCOUT                (BCOUT),
        .INMODE_OUT           (INMODE_OUT),
        .configuration_input  (configuration_input),
        .configuration_enable (configuration_enable),
        .configuration_output (configuration_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    // Shift a full 10-bit word so that the chain ends holding pat (bit 9 first).
    task automatic shift_cfg(input logic [9:0] pat);
        configuration_enable = 1'b1;
        for (int i = 9; i >= 0; i--) begin
            configuration_input = pat[i];
            clk_step();
        end
        configuration_enable = 1'b0;
        configuration_input  = 1'b0;
    endtask

    logic [9:0] pat;

    initial begin
        rst_n = 1'b0;
        A = 30'h1234; ACIN = '0; B = 18'h0abc; BCIN = '0;
        CEA1 = 1'b1; CEA2 = 1'b1; CEB1 = 1'b1; CEB2 = 1'b1;
        RSTA = 1'b0; RSTB = 1'b0;
        INMODE = 5'h01; CEINMODE = 1'b1; RSTINMODE = 1'b0;
        configuration_input = 1'b0; configuration_enable = 1'b0;

        // Reset: everything combinational from the direct inputs.
        #3;
        check_eq("rst_a2a1", 32'(A2A1), 32'h1234);
        check_eq("rst_acout", 32'(ACOUT), 32'h1234);
        check_eq("rst_bcout", 32'(BCOUT), 32'h0abc);
        check_eq("rst_b2b1", 32'(B2B1), 32'h0abc);
        check_eq("rst_inmode_out", 32'(INMODE_OUT), 32'h01);
        check_eq("rst_cfg_out", 32'(configuration_output), 32'h0);
        clk_step();
        clk_step();
        rst_n = 1'b1;

        // AREG=2, BREG=1, direct inputs.
        A = '0; B = '0;
        shift_cfg(10'h018);
        clk_step();
        clk_step();
        A = 30'd5; B = 18'd9;
        #1;
        check_eq("lat_acout_t0", 32'(ACOUT), 32'd0);
        clk_step();
        check_eq("lat_a2a1_t1", 32'(A2A1), 32'd5);
        check_eq("lat_acout_t1", 32'(ACOUT), 32'd0);
        check_eq("lat_bcout_t1", 32'(BCOUT), 32'd9);
        check_eq("lat_b2b1_t1", 32'(B2B1), 32'd9);
        A = 30'd7;
        clk_step();
        check_eq("lat_acout_t2", 32'(ACOUT), 32'd5);
        check_eq("lat_a2a1_t2", 32'(A2A1), 32'd7);
        clk_step();
        check_eq("lat_acout_t3", 32'(ACOUT), 32'd7);

        // A1 advances, A2 holds.
        CEA2 = 1'b0; A = 30'd11;
        clk_step();
        check_eq("cea2_a1_adv", 32'(A2A1), 32'd11);
        check_eq("cea2_a2_hold", 32'(ACOUT), 32'd7);
        CEA2 = 1'b1;

        // Cascade A input, all ones.
        ACIN = 30'h3FFFFFFF;
        shift_cfg(10'h019);
        clk_step();
        clk_step();
        check_eq("acin_acout", 32'(ACOUT), 32'h3FFFFFFF);
        check_eq("acin_a2a1", 32'(A2A1), 32'h7FFFFFF);

        // Inverted RSTB: RSTB=1 is idle, RSTB=0 clears even with CEs low.
        RSTB = 1'b1;
        shift_cfg(10'h119);
        B = 18'h2AA;
        clk_step();
        check_eq("rstb_inv_load", 32'(BCOUT), 32'h2AA);
        CEB1 = 1'b0; CEB2 = 1'b0; B = 18'h155;
        clk_step();
        check_eq("rstb_ce_hold", 32'(BCOUT), 32'h2AA);
        RSTB = 1'b0;
        #1;
        check_eq("rstb_sync_only", 32'(BCOUT), 32'h2AA);
        clk_step();
        check_eq("rstb_clr_bcout", 32'(BCOUT), 32'h0);
        check_eq("rstb_clr_b2b1", 32'(B2B1), 32'h0);

        // Registered INMODE, BREG=2, inverted RSTB kept idle.
        RSTB = 1'b1; CEB1 = 1'b1; CEB2 = 1'b1; INMODE = 5'h00; B = '0;
        shift_cfg(10'h168);
        B = 18'h111;
        clk_step();
        B = 18'h222;
        clk_step();
        check_eq("inm_out_pre", 32'(INMODE_OUT), 32'h00);
        check_eq("inm_b2b1_pre", 32'(B2B1), 32'h111);
        B = 18'h333; INMODE = 5'h11;
        #1;
        check_eq("inm_out_not_comb", 32'(INMODE_OUT), 32'h00);
        check_eq("inm_b2b1_not_comb", 32'(B2B1), 32'h111);
        clk_step();
        check_eq("inm_out_post", 32'(INMODE_OUT), 32'h11);
        check_eq("inm_b2b1_b1", 32'(B2B1), 32'h333);
        check_eq("inm_bcout_b2", 32'(BCOUT), 32'h222);
        RSTINMODE = 1'b1;
        clk_step();
        check_eq("inm_rst", 32'(INMODE_OUT), 32'h00);
        RSTINMODE = 1'b0;

        // Chain round trip: pattern then ten zeros.
        pat = 10'h2D6;
        shift_cfg(pat);
        configuration_enable = 1'b1;
        configuration_input  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check_eq($sformatf("chain_bit%0d", 9 - k), 32'(configuration_output),
                     32'(pat[9-k]));
            clk_step();
        end
        configuration_enable = 1'b0;
        check_eq("chain_flushed", 32'(configuration_output), 32'h0);
        A = 30'h0ABCDEF; INMODE = 5'h01;
        #1;
        check_eq("cfg_zero_acout", 32'(ACOUT), 32'h0ABCDEF);
        check_eq("cfg_zero_a2a1", 32'(A2A1), 32'h0ABCDEF);

        // rst_n mid-shift discards the partial word.
        configuration_enable = 1'b1; configuration_input = 1'b1;
        for (int k = 0; k < 5; k++) clk_step();
        configuration_enable = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("midshift_rst_out", 32'(configuration_output), 32'h0);
        rst_n = 1'b1;
        configuration_enable = 1'b1; configuration_input = 1'b0;
        for (int k = 0; k < 5; k++) clk_step();
        configuration_enable = 1'b0;
        check_eq("midshift_cleared", 32'(configuration_output), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ab_input_register_block.md
# ab_input_register_block

Input register stage for the A and B operand ports of the DSP slice. It sits directly upstream of the pre-adder/D register stage. It selects direct or cascade inputs, runs the programmable A1/A2 and B1/B2 pipelines and the INMODE register, and produces `A2A1`, `B2B1` and the registered `INMODE` consumed by the pre-adder. Its static configuration is loaded through the slice's serial configuration chain.

## Interface
Parameters:
- `input_freezed`, default 1'b0: when 1, all pipeline muxes are forced to their registered paths, as if `AREG`=`BREG`=2 and `INMODEREG`=1.

Ports:
- `clk`  in  1  slice clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. Clears every data register and every configuration bit.
- `A`  in  30  direct A operand.
- `ACIN`  in  30  A cascade input.
- `B`  in  18  direct B operand.
- `BCIN`  in  18  B cascade input.
- `CEA1`, `CEA2`, `CEB1`, `CEB2`  in  1 each  per-register clock enables.
- `RSTA`, `RSTB`  in  1 each  synchronous resets for the A and B registers; polarity is programmable.
- `INMODE`  in  5  raw mode input.
- `CEINMODE`  in  1  enable for the INMODE register.
- `RSTINMODE`  in  1  synchronous reset for the INMODE register; polarity is programmable.
- `A2A1`  out  27  lower 27 bits of the A operand selected for the pre-adder.
- `B2B1`  out  18  B operand selected for the pre-adder.
- `ACOUT`  out  30  A cascade output.
- `BCOUT`  out  18  B cascade output.
- `INMODE_OUT`  out  5  effective INMODE, passed to the pre-adder stage.
- `configuration_input`  in  1  serial configuration data in.
- `configuration_enable`  in  1  shifts the configuration chain by one bit per clock while high.
- `configuration_output`  out  1  serial configuration data out.

## Operation
- The configuration chain is 10 bits. While `configuration_enable` is high, it shifts each clock in this order: `configuration_input` → `A_INPUT` → `B_INPUT` → `AREG[0]` → `AREG[1]` → `BREG[0]` → `BREG[1]` → `INMODEREG` → `IS_RSTA_INVERTED` → `IS_RSTB_INVERTED` → `IS_RSTINMODE_INVERTED` → `configuration_output`.
- Input select:
  - `A_sel` = `A_INPUT` ? `ACIN` : `A`.
  - `B_sel` = `B_INPUT` ? `BCIN` : `B`.
- Effective synchronous resets:
  - `RSTA_x` = `RSTA` ^ `IS_RSTA_INVERTED`.
  - `RSTB_x` = `RSTB` ^ `IS_RSTB_INVERTED`.
  - `RSTINMODE_x` = `RSTINMODE` ^ `IS_RSTINMODE_INVERTED`.
- A1 register: `RSTA_x` clears it to 0; otherwise it loads `A_sel` when `CEA1` is high.
- A2 register: `RSTA_x` clears it to 0; otherwise it loads `A1_reg` when `AREG`≥2, else `A_sel`, when `CEA2` is high.
- A path taps:
  - `a2_path` = (`AREG`==0) ? `A_sel` : `A2_reg`.
  - `a1_path` = (`AREG`≥2) ? `A1_reg` : `a2_path`.
  - `AREG`=3 behaves exactly as `AREG`=2.
- The B pipeline is identical in structure, using `BREG`, `CEB1`/`CEB2` and `RSTB_x`.
- INMODE register:
  - `RSTINMODE_x` clears it to 0; otherwise it loads `INMODE` when `CEINMODE` is high.
  - `INMODE_OUT` = `INMODEREG` ? `INMODE_reg` : `INMODE`.
- Outputs:
  - `A2A1` = `INMODE_OUT[0]` ? `a1_path[26:0]` : `a2_path[26:0]`.
  - `B2B1` = `INMODE_OUT[4]` ? `b1_path` : `b2_path`.
  - `ACOUT` = `a2_path`; `BCOUT` = `b2_path`.

## Timing
- `rst_n` low: all registers, including configuration bits, are cleared immediately. The block is then in all-combinational mode with direct inputs, so outputs follow `A`, `B` and `INMODE` combinationally.
- Latency from `A` to `ACOUT` is `AREG` clocks: 0, 1 or 2, with all CEs high. The same holds for B with `BREG`.
- Priority within a clock: `rst_n` first, then the synchronous reset, then the CE.
- A synchronous reset with CE low still clears the register.
- `configuration_enable` high during operation: configuration bits change at the clock edge and the data paths re-select combinationally. Data registers are not disturbed.
- `rst_n` asserted mid-shift: the configuration chain is cleared and the shift restarts from zero bits.
- With `CEA1`=1 and `CEA2`=0, A1 advances while A2 holds. The bench checks that A1 and A2 differ.

## Structure
- A shared package `dsp_cfg_pkg` holds the REG-depth encodings (0/1/2) and the chain length constant `AB_CFG_BITS`=10.
- Sub-module `operand_pipe`, parameterised by `WIDTH`, is instantiated twice (A: 30, B: 18). It contains the two registers, the depth mux and the `a1_path`/`a2_path` taps.

## Test plan
- Reset: `rst_n`=0, `A`=30'h1234, `INMODE`=5'h1 → `A2A1`=27'h1234 and `ACOUT`=30'h1234 combinationally, and `configuration_output`=0.
- Shift 10 bits so that `AREG`=2 and `BREG`=1, all CEs high. Drive `A`=5 then 7 on consecutive cycles → `ACOUT`=5 exactly two clocks after `A`=5. With `INMODE`=1, `A2A1` shows the A1 value one clock earlier than `ACOUT`.
- Set `A_INPUT`=1 and `ACIN`=30'h3FFFFFFF → `ACOUT`=30'h3FFFFFFF and `A2A1`=27'h7FFFFFF after the pipeline fill.
- Set `IS_RSTB_INVERTED`=1 and `RSTB`=0 with `CEB1`=`CEB2`=0 → `b1_path` and `b2_path` are cleared to 0 next clock, so `BCOUT`=0 and `B2B1`=0.
- Set `INMODEREG`=1 and `CEINMODE`=1. Change `INMODE` 0→5'h11 → `INMODE_OUT` updates one clock later, and `B2B1` switches from `b2_path` to `b1_path` in that same cycle.
- Shift a 10-bit pattern, then shift 10 zeros → the original pattern appears on `configuration_output` in order, and the configuration bits end at 0.
